// File: rtl/hdmi_pair_codec_pkg.sv
// ============================================================================
// Module  : codec_pkg
// Purpose : Shared widths, quantizer constants and the output saturator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package codec_pkg;

    localparam int PIX_W   = 8;
    localparam int SD_W    = 10;
    localparam int Q_SHIFT = 2;
    localparam int Q_ROUND = 2;
    localparam int LATENCY = 4;

    localparam logic signed [SD_W:0] SAT_MAX = 11'sd127;
    localparam logic signed [SD_W:0] SAT_MIN = -11'sd128;

    // Clamp a reconstructed half-sum back into the signed pixel range.
    function automatic logic signed [PIX_W-1:0] saturate(input logic signed [SD_W:0] x);
        logic signed [PIX_W-1:0] r;
        if (x > SAT_MAX) begin
            r = 8'sh7f;
        end else if (x < SAT_MIN) begin
            r = 8'sh80;
        end else begin
            r = x[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hdmi_pair_codec_if.sv
// ============================================================================
// Module  : hdmi_pair_codec_if
// Purpose : HDMI-style YCrCb pixel bus, N pixels per beat, with syncs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface hdmi_pair_codec_if #(
    parameter int N = 2
);
    logic              v_sync;
    logic              h_sync;
    logic              data_valid;
    logic [N-1:0][7:0] data_y;
    logic [N-1:0][7:0] data_cr;
    logic [N-1:0][7:0] data_cb;

    modport master (
        output v_sync,
        output h_sync,
        output data_valid,
        output data_y,
        output data_cr,
        output data_cb
    );

    modport slave (
        input v_sync,
        input h_sync,
        input data_valid,
        input data_y,
        input data_cr,
        input data_cb
    );
endinterface

`default_nettype wire

// File: rtl/hdmi_pair_codec_pair_codec.sv
// ============================================================================
// Module  : pair_codec
// Purpose : 4-stage sum/difference transform with quantized difference term.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pair_codec
    import codec_pkg::*;
(
    input  wire logic                    clk,
    input  wire logic                    rst_n,
    input  wire logic                    i_en,
    input  wire logic signed [PIX_W-1:0] i_a,
    input  wire logic signed [PIX_W-1:0] i_b,
    output logic signed [PIX_W-1:0]      o_a,
    output logic signed [PIX_W-1:0]      o_b
);

    logic signed [PIX_W-1:0] r1_a;
    logic signed [PIX_W-1:0] r1_b;
    logic                    r1_en;
    logic signed [SD_W-1:0]  r2_s;
    logic signed [SD_W-1:0]  r2_d;
    logic                    r2_en;
    logic signed [SD_W-1:0]  r3_s;
    logic signed [SD_W-1:0]  r3_d;
    logic signed [PIX_W-1:0] r4_a;
    logic signed [PIX_W-1:0] r4_b;

    logic signed [SD_W-1:0]  w_d_rnd;
    logic signed [SD_W-1:0]  w_d_q;
    logic signed [SD_W-1:0]  w_d_deq;
    logic signed [SD_W:0]    w_sum;
    logic signed [SD_W:0]    w_dif;
    logic signed [SD_W:0]    w_a_half;
    logic signed [SD_W:0]    w_b_half;

    // Round-half-up onto a multiple of 4; |d| <= 255 so no 10-bit overflow.
    assign w_d_rnd  = r2_d + SD_W'(Q_ROUND);
    assign w_d_q    = w_d_rnd >>> Q_SHIFT;
    assign w_d_deq  = w_d_q <<< Q_SHIFT;

    // One extra bit keeps s +/- d' exact before the halving shift.
    assign w_sum    = (SD_W+1)'(r3_s) + (SD_W+1)'(r3_d);
    assign w_dif    = (SD_W+1)'(r3_s) - (SD_W+1)'(r3_d);
    assign w_a_half = w_sum >>> 1;
    assign w_b_half = w_dif >>> 1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_a  <= '0;
            r1_b  <= '0;
            r1_en <= 1'b0;
            r2_s  <= '0;
            r2_d  <= '0;
            r2_en <= 1'b0;
            r3_s  <= '0;
            r3_d  <= '0;
            r4_a  <= '0;
            r4_b  <= '0;
        end else begin
            r1_a  <= i_a;
            r1_b  <= i_b;
            r1_en <= i_en;
            r2_s  <= SD_W'(r1_a) + SD_W'(r1_b);
            r2_d  <= SD_W'(r1_a) - SD_W'(r1_b);
            r2_en <= r1_en;
            r3_s  <= r2_s;
            r3_d  <= r2_en ? w_d_deq : r2_d;
            r4_a  <= saturate(w_a_half);
            r4_b  <= saturate(w_b_half);
        end
    end

    assign o_a = r4_a;
    assign o_b = r4_b;

endmodule

`default_nettype wire

// File: rtl/hdmi_pair_codec.sv
// ============================================================================
// Module  : hdmi_pair_codec
// Purpose : Lossy pairwise YCrCb encode/decode loopback with delayed syncs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hdmi_pair_codec
    import codec_pkg::*;
#(
    parameter int N     = 2,
    parameter int X_RES = 2160,
    parameter int Y_RES = 1200
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          en,
    hdmi_pair_codec_if.slave   i_hdmi,
    hdmi_pair_codec_if.master  o_hdmi
);

    localparam int NPAIR = N / 2;
    localparam int NCOMP = 3;

    if ((N % 2) != 0 || N < 2 || X_RES < 1 || Y_RES < 1) begin : g_bad_params
        $error("hdmi_pair_codec: N must be even and resolutions positive");
    end

    logic [NCOMP-1:0][N-1:0][PIX_W-1:0] w_comp_in;
    logic [NCOMP-1:0][N-1:0][PIX_W-1:0] w_comp_out;
    logic [LATENCY-1:0][2:0]            r_ctrl_pipe;
    logic [2:0]                         w_ctrl_out;

    assign w_comp_in = {i_hdmi.data_cb, i_hdmi.data_cr, i_hdmi.data_y};

    for (genvar c = 0; c < NCOMP; c++) begin : g_comp
        for (genvar k = 0; k < NPAIR; k++) begin : g_pair
            pair_codec u_pair (
                .clk   (clk),
                .rst_n (rst_n),
                .i_en  (en),
                .i_a   (w_comp_in[c][2*k]),
                .i_b   (w_comp_in[c][2*k+1]),
                .o_a   (w_comp_out[c][2*k]),
                .o_b   (w_comp_out[c][2*k+1])
            );
        end
    end

    // Syncs and valid ride a shift register matched to the pixel pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl_pipe <= '0;
        end else begin
            r_ctrl_pipe <= {r_ctrl_pipe[LATENCY-2:0],
                            {i_hdmi.v_sync, i_hdmi.h_sync, i_hdmi.data_valid}};
        end
    end

    assign w_ctrl_out        = r_ctrl_pipe[LATENCY-1];
    assign o_hdmi.v_sync     = w_ctrl_out[2];
    assign o_hdmi.h_sync     = w_ctrl_out[1];
    assign o_hdmi.data_valid = w_ctrl_out[0];
    assign o_hdmi.data_y     = w_ctrl_out[0] ? w_comp_out[0] : '0;
    assign o_hdmi.data_cr    = w_ctrl_out[0] ? w_comp_out[1] : '0;
    assign o_hdmi.data_cb    = w_ctrl_out[0] ? w_comp_out[2] : '0;

endmodule

`default_nettype wire

// File: tb/tb_hdmi_pair_codec.sv
// ============================================================================
// Module  : tb_hdmi_pair_codec
// Purpose : Self-checking bench for hdmi_pair_codec against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hdmi_pair_codec;

    localparam int N     = 2;
    localparam int W     = N * 8;
    localparam int H_ACT = 24;

    typedef struct packed {
        logic         vs;
        logic         hs;
        logic         vld;
        logic         en;
        logic [W-1:0] y;
        logic [W-1:0] cr;
        logic [W-1:0] cb;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #5 clk = ~clk;

    hdmi_pair_codec_if #(.N(N)) in_if ();
    hdmi_pair_codec_if #(.N(N)) out_if ();

    hdmi_pair_codec #(.N(N), .X_RES(2160), .Y_RES(1200)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .i_hdmi (in_if),
        .o_hdmi (out_if)
    );

    int    checks  = 0;
    int    errors  = 0;
    int    cnt_in  = 0;
    int    cnt_out = 0;
    int    lat;
    int    ramp    = 0;
    beat_t pipe [4];

    function automatic int fdiv(input int x, input int m);
        return (x >= 0) ? (x / m) : -((-x + m - 1) / m);
    endfunction

    function automatic logic [7:0] sat8(input int x);
        if (x > 127)  return 8'h7f;
        if (x < -128) return 8'h80;
        return 8'(x);
    endfunction

    // Reference: a' = (s + d')/2, b' = (s - d')/2, d' = 4*floor((d+2)/4) when enabled.
    function automatic logic [W-1:0] comp_model(input logic [W-1:0] v, input logic e);
        logic [W-1:0] r;
        int a, b, s, d;
        r = '0;
        for (int k = 0; k < N/2; k++) begin
            a = $signed(v[16*k +: 8]);
            b = $signed(v[16*k+8 +: 8]);
            s = a + b;
            d = a - b;
            if (e) d = 4 * fdiv(d + 2, 4);
            r[16*k +: 8]   = sat8(fdiv(s + d, 2));
            r[16*k+8 +: 8] = sat8(fdiv(s - d, 2));
        end
        return r;
    endfunction

    function automatic beat_t model(input beat_t b);
        beat_t r;
        r     = '0;
        r.vs  = b.vs;
        r.hs  = b.hs;
        r.vld = b.vld;
        if (b.vld) begin
            r.y  = comp_model(b.y, b.en);
            r.cr = comp_model(b.cr, b.en);
            r.cb = comp_model(b.cb, b.en);
        end
        return r;
    endfunction

    function automatic logic within_tol(input beat_t b);
        logic [W-1:0] iv, ov;
        int diff;
        logic ok;
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            iv = (c == 0) ? b.y : (c == 1) ? b.cr : b.cb;
            ov = (c == 0) ? out_if.data_y : (c == 1) ? out_if.data_cr : out_if.data_cb;
            for (int l = 0; l < N; l++) begin
                diff = int'($signed(ov[8*l +: 8])) - int'($signed(iv[8*l +: 8]));
                if (b.en ? (diff < -1 || diff > 1) : (diff != 0)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic hs, input logic vld,
                         input logic [W-1:0] y, input logic [W-1:0] cr, input logic [W-1:0] cb);
        in_if.v_sync     = vs;
        in_if.h_sync     = hs;
        in_if.data_valid = vld;
        in_if.data_y     = y;
        in_if.data_cr    = cr;
        in_if.data_cb    = cb;
    endtask

    task automatic drive_ramp(input logic vs);
        logic [W-1:0] y, cr, cb;
        for (int l = 0; l < N; l++) begin
            y[8*l +: 8]  = 8'(ramp + l);
            cr[8*l +: 8] = 8'(ramp + l + 50);
            cb[8*l +: 8] = 8'(ramp + l + 100);
        end
        ramp = (ramp + 1) % 256;
        drive(vs, 1'b0, 1'b1, y, cr, cb);
    endtask

    task automatic drive_idle(input logic vs, input logic hs);
        drive(vs, hs, 1'b0, W'($urandom), W'($urandom), W'($urandom));
    endtask

    // One clock: advance the model, then compare every output field.
    task automatic tick();
        beat_t cur, e;
        @(posedge clk);
        cur.vs  = in_if.v_sync;
        cur.hs  = in_if.h_sync;
        cur.vld = in_if.data_valid;
        cur.en  = en;
        cur.y   = in_if.data_y;
        cur.cr  = in_if.data_cr;
        cur.cb  = in_if.data_cb;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) pipe[i] = '0;
        end else begin
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = cur;
            if (cur.vld) cnt_in++;
        end
        #1;
        e = model(pipe[3]);
        chk("ctrl", W'({out_if.v_sync, out_if.h_sync, out_if.data_valid}), W'({e.vs, e.hs, e.vld}));
        chk("data_y",  out_if.data_y,  e.y);
        chk("data_cr", out_if.data_cr, e.cr);
        chk("data_cb", out_if.data_cb, e.cb);
        if (out_if.data_valid) cnt_out++;
        if (pipe[3].vld) chk("tolerance", W'(within_tol(pipe[3])), W'(1));
    endtask

    task automatic wait_valid();
        lat = 1;
        tick();
        drive_idle(1'b0, 1'b0);
        while (!out_if.data_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    task automatic video_line(input logic vs, input logic act, input int hblank, input int mode);
        for (int i = 0; i < hblank; i++) begin
            drive_idle(vs, (i < 2));
            tick();
        end
        for (int i = 0; i < H_ACT; i++) begin
            if (!act) begin
                drive_idle(vs, 1'b0);
            end else if (mode == 2) begin
                en = 1'($urandom_range(0, 1));
                drive(vs, 1'b0, 1'b1, W'($urandom), W'($urandom), W'($urandom));
            end else begin
                en = 1'b1;
                drive_ramp(vs);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pipe[i] = '0;

        // Reset held with live valid input.
        en = 1'b1;
        drive(1'b1, 1'b1, 1'b1, W'($urandom), W'($urandom), W'($urandom));
        repeat (2) tick();
        chk("reset_y", out_if.data_y, '0);
        chk("reset_ctrl", W'({out_if.v_sync, out_if.h_sync, out_if.data_valid}), '0);

        rst_n = 1'b1;
        drive_idle(1'b0, 1'b0);
        repeat (3) tick();

        // Quantization example and first-beat latency.
        drive(1'b0, 1'b0, 1'b1, {8'd3, 8'd10}, W'($urandom), W'($urandom));
        wait_valid();
        chk("latency", W'(lat), W'(4));
        chk("quant_y", out_if.data_y, {8'd2, 8'd10});
        repeat (3) tick();

        // Saturation of b' = -129.
        drive(1'b0, 1'b0, 1'b1, {8'h80, 8'h7f}, W'($urandom), W'($urandom));
        wait_valid();
        chk("sat_latency", W'(lat), W'(4));
        chk("sat_y", out_if.data_y, {8'h80, 8'h7f});
        repeat (3) tick();

        // Bypass ramp must be bit-exact.
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive_ramp(1'b0);
            tick();
        end
        drive_idle(1'b0, 1'b0);
        repeat (5) tick();

        // Reduced frames; frame 1 has back-to-back valid lines, frame 2 random data and en.
        cnt_in  = 0;
        cnt_out = 0;
        ramp    = 0;
        for (int f = 0; f < 3; f++) begin
            int hb;
            hb = (f == 1) ? 0 : 4;
            repeat (2) video_line(1'b1, 1'b0, 4, f);
            repeat (3) video_line(1'b0, 1'b0, 4, f);
            repeat (6) video_line(1'b0, 1'b1, hb, f);
            repeat (2) video_line(1'b0, 1'b0, 4, f);
        end
        drive_idle(1'b0, 1'b0);
        repeat (5) tick();
        chk("beat_count", W'(cnt_out), W'(cnt_in));
        chk("beat_count_nz", W'(cnt_in != 0), W'(1));

        // Reset in the middle of an active line.
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_ramp(1'b0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("midreset_y", out_if.data_y, '0);
        chk("midreset_ctrl", W'({out_if.v_sync, out_if.h_sync, out_if.data_valid}), '0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, {8'd3, 8'd10}, W'($urandom), W'($urandom));
        wait_valid();
        chk("midreset_latency", W'(lat), W'(4));
        chk("midreset_quant_y", out_if.data_y, {8'd2, 8'd10});
        for (int i = 0; i < 10; i++) begin
            drive_ramp(1'b0);
            tick();
        end
        drive_idle(1'b0, 1'b0);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
